// File: rtl/mac_pkg.sv
// Shared types, default widths and the saturating adder used by the MAC pipeline.
package mac_pkg;

    typedef enum logic {
        MADD = 1'b0,
        MAC  = 1'b1
    } mode_e;

    localparam int unsigned DefWidth     = 8;
    localparam int unsigned DefOutWidth  = 16;
    localparam int unsigned DefPipeDepth = 3;

    // Widest result the saturating adder supports; callers zero-extend into it.
    localparam int unsigned MaxOutWidth  = 64;

    // Adds two values and clamps to a w-bit unsigned maximum.
    // Returns {ovf, result}; only the low w bits of result are meaningful.
    function automatic logic [MaxOutWidth:0] sat_add(
        input logic [MaxOutWidth-1:0] a,
        input logic [MaxOutWidth-1:0] b,
        input int unsigned            w
    );
        logic [MaxOutWidth:0] sum;
        logic [MaxOutWidth:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ({{MaxOutWidth{1'b0}}, 1'b1} << w) - {{MaxOutWidth{1'b0}}, 1'b1};
        if (sum > lim) begin
            sat_add = {1'b1, lim[MaxOutWidth-1:0]};
        end else begin
            sat_add = {1'b0, sum[MaxOutWidth-1:0]};
        end
    endfunction

endpackage

// File: rtl/mac_delay_line.sv
// DEPTH-stage {valid, data} shift register; all stages move together on en.
module mac_delay_line
    import mac_pkg::*;
#(
    parameter int unsigned DEPTH = DefPipeDepth,
    parameter int unsigned DW    = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);

    logic [DEPTH-1:0] valid_q;
    logic [DW-1:0]    data_q [DEPTH];

    // Shift valid and data one stage per enabled cycle; bubbles travel like beats.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else if (en) begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_data;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/mac_pipeline.sv
// Pipelined multiply-add / multiply-accumulate with unsigned saturation and
// valid/ready flow control. OUT_WIDTH must be >= 2*WIDTH and <= 64; PIPE_DEPTH >= 1.
module mac_pipeline
    import mac_pkg::*;
#(
    parameter int unsigned WIDTH      = DefWidth,
    parameter int unsigned OUT_WIDTH  = DefOutWidth,
    parameter int unsigned PIPE_DEPTH = DefPipeDepth
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [WIDTH-1:0]     in_c,
    input  logic                 in_mode,
    input  logic                 in_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_result,
    output logic                 out_ovf
);

    logic adv;

    // Stage 1: product register
    logic                 v1_q;
    logic [2*WIDTH-1:0]   p1_q;
    logic [WIDTH-1:0]     c1_q;
    mode_e                mode1_q;
    logic                 clr1_q;

    // Stage 2: saturated sum register and the running accumulator
    logic                 v2_q;
    logic [OUT_WIDTH-1:0] res2_q;
    logic                 ovf2_q;
    logic [OUT_WIDTH-1:0] acc_q;

    logic [OUT_WIDTH-1:0] addend;
    logic [MaxOutWidth:0] sum;
    logic [OUT_WIDTH-1:0] res2_d;
    logic                 ovf2_d;
    logic                 unused_sum_hi;

    logic [OUT_WIDTH:0]   dl_out_data;

    // Whole pipeline moves in lockstep whenever the output slot is free or draining.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Capture the accepted beat and its product.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_q    <= 1'b0;
            p1_q    <= '0;
            c1_q    <= '0;
            mode1_q <= MADD;
            clr1_q  <= 1'b0;
        end else if (adv) begin
            v1_q    <= in_valid && in_ready;
            p1_q    <= (2*WIDTH)'(in_a) * (2*WIDTH)'(in_b);
            c1_q    <= in_c;
            mode1_q <= mode_e'(in_mode);
            clr1_q  <= in_clr;
        end
    end

    // Select the addend by mode and saturate the sum; clr only matters in MAC mode.
    always_comb begin
        addend = OUT_WIDTH'(c1_q);
        if (mode1_q == MAC) begin
            addend = clr1_q ? '0 : acc_q;
        end
        sum           = sat_add(MaxOutWidth'(p1_q), MaxOutWidth'(addend), OUT_WIDTH);
        res2_d        = sum[OUT_WIDTH-1:0];
        ovf2_d        = sum[MaxOutWidth];
        unused_sum_hi = ^(sum >> OUT_WIDTH);
    end

    // Register the result; only valid MAC beats write the accumulator, and the
    // saturated value is what gets kept so overflow stays pinned until a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v2_q   <= 1'b0;
            res2_q <= '0;
            ovf2_q <= 1'b0;
            acc_q  <= '0;
        end else if (adv) begin
            v2_q   <= v1_q;
            res2_q <= res2_d;
            ovf2_q <= ovf2_d;
            if (v1_q && (mode1_q == MAC)) begin
                acc_q <= res2_d;
            end
        end
    end

    mac_delay_line #(
        .DEPTH (PIPE_DEPTH),
        .DW    (OUT_WIDTH + 1)
    ) u_delay (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (adv),
        .in_valid  (v2_q),
        .in_data   ({ovf2_q, res2_q}),
        .out_valid (out_valid),
        .out_data  (dl_out_data)
    );

    assign out_result = dl_out_data[OUT_WIDTH-1:0];
    assign out_ovf    = dl_out_data[OUT_WIDTH];

endmodule

// File: tb/tb_mac_pipeline.sv
// Randomised and directed bench for mac_pipeline against a queue-based reference model.
module tb_mac_pipeline;

    localparam int W  = 8;
    localparam int OW = 16;
    localparam int PD = 3;
    localparam longint MAXV = (longint'(1) << OW) - 1;
    localparam int LAT = PD + 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [W-1:0]  in_c;
    logic          in_mode;
    logic          in_clr;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_result;
    logic          out_ovf;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        longint res;
        bit     ovf;
        int     cyc;
    } exp_t;

    exp_t   exp_q[$];
    longint got_res[$];
    bit     got_ovf[$];
    int     got_lat[$];
    longint model_acc = 0;

    mac_pipeline #(
        .WIDTH      (W),
        .OUT_WIDTH  (OW),
        .PIPE_DEPTH (PD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_c       (in_c),
        .in_mode    (in_mode),
        .in_clr     (in_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ovf    (out_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // One cycle: called at a negedge with inputs set; samples just before the
    // posedge, checks any delivered result, models any accepted beat.
    task automatic tick(output bit acc, output bit rdy);
        exp_t   e;
        longint prod;
        longint s;
        #3;
        cyc++;
        rdy = in_ready;
        chk("in_ready_rule", longint'(in_ready), longint'(!out_valid || out_ready));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL spurious_output: got result %0d, expected no beat", out_result);
            end else begin
                e = exp_q.pop_front();
                chk("result", longint'(out_result), e.res);
                chk("ovf", longint'(out_ovf), longint'(e.ovf));
                got_res.push_back(longint'(out_result));
                got_ovf.push_back(out_ovf);
                got_lat.push_back(cyc - e.cyc);
            end
        end
        acc = in_valid && in_ready;
        if (acc) begin
            prod = longint'(in_a) * longint'(in_b);
            if (in_mode == 1'b0) s = prod + longint'(in_c);
            else s = (in_clr ? 0 : model_acc) + prod;
            e.ovf = (s > MAXV);
            e.res = e.ovf ? MAXV : s;
            e.cyc = cyc;
            if (in_mode == 1'b1) model_acc = e.res;
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic send(input bit m, input int a, input int b, input int c, input bit clr);
        bit acc;
        bit rdy;
        int n = 0;
        in_valid = 1'b1;
        in_mode  = m;
        in_a     = W'(a);
        in_b     = W'(b);
        in_c     = W'(c);
        in_clr   = clr;
        do begin
            tick(acc, rdy);
            n++;
        end while (!acc && n < 100);
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: in_ready stayed %0d, required 1", in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        bit rdy;
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 60) begin
            tick(acc, rdy);
            n++;
        end
        if (n >= 60) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic expect_out(input string name, input int idx, input longint res, input bit ovf);
        if (idx >= got_res.size()) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: missing output #%0d, expected %0d", name, idx, res);
        end else begin
            chk({name, "_res"}, got_res[idx], res);
            chk({name, "_ovf"}, longint'(got_ovf[idx]), longint'(ovf));
        end
    endtask

    task automatic expect_lat(input string name, input int idx);
        if (idx < got_lat.size()) chk(name, longint'(got_lat[idx]), longint'(LAT));
    endtask

    initial begin
        int  g0;
        int  i;
        int  t;
        bit  acc;
        bit  rdy;

        reset_n   = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_c      = '0;
        in_mode   = 1'b0;
        in_clr    = 1'b0;
        out_ready = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_result", longint'(out_result), 0);
        chk("rst_out_ovf", longint'(out_ovf), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Latency and full-scale MADD
        g0 = got_res.size();
        send(1'b0, 255, 255, 255, 1'b0);
        drain();
        expect_out("s1", g0, 65280, 1'b0);
        expect_lat("s1_latency", g0);

        // Back-to-back accumulation
        g0 = got_res.size();
        send(1'b1, 10, 20, 0, 1'b1);
        send(1'b1, 3, 4, 0, 1'b0);
        send(1'b1, 1, 1, 0, 1'b0);
        drain();
        expect_out("s2_a", g0, 200, 1'b0);
        expect_out("s2_b", g0 + 1, 212, 1'b0);
        expect_out("s2_c", g0 + 2, 213, 1'b0);
        for (int k = 0; k < 3; k++) expect_lat("s2_latency", g0 + k);

        // Saturation stays pinned until clear
        g0 = got_res.size();
        send(1'b1, 255, 255, 0, 1'b1);
        send(1'b1, 255, 255, 0, 1'b0);
        send(1'b1, 1, 1, 0, 1'b0);
        send(1'b1, 2, 2, 0, 1'b1);
        drain();
        expect_out("s3_a", g0, 65025, 1'b0);
        expect_out("s3_b", g0 + 1, 65535, 1'b1);
        expect_out("s3_c", g0 + 2, 65535, 1'b1);
        expect_out("s3_d", g0 + 3, 4, 1'b0);

        // MADD between MAC beats leaves the accumulator alone
        g0 = got_res.size();
        send(1'b1, 2, 3, 0, 1'b1);
        send(1'b0, 5, 5, 7, 1'b1);
        send(1'b1, 1, 1, 0, 1'b0);
        drain();
        expect_out("s4_a", g0, 6, 1'b0);
        expect_out("s4_b", g0 + 1, 32, 1'b0);
        expect_out("s4_c", g0 + 2, 7, 1'b0);

        // Backpressure mid-stream
        g0 = got_res.size();
        i = 1;
        t = 0;
        while (i <= 8 && t < 100) begin
            out_ready = !(t >= 4 && t < 10);
            in_valid  = 1'b1;
            in_mode   = 1'b0;
            in_clr    = 1'b0;
            in_a      = W'(i);
            in_b      = 8'd1;
            in_c      = 8'd0;
            tick(acc, rdy);
            if (t == 7) chk("s5_in_ready_stalled", longint'(rdy), 0);
            if (acc) i++;
            t++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(1'b1, 1, 1, 0, 1'b0);
        drain();
        chk("s5_count", longint'(got_res.size() - g0), 9);
        for (int k = 0; k < 8; k++) expect_out("s5_stream", g0 + k, longint'(k + 1), 1'b0);
        expect_out("s5_acc_kept", g0 + 8, 8, 1'b0);

        // Reset with beats in flight
        send(1'b1, 4, 4, 0, 1'b1);
        send(1'b1, 4, 4, 0, 1'b0);
        send(1'b1, 4, 4, 0, 1'b0);
        tick(acc, rdy);
        tick(acc, rdy);
        chk("s6_pre_rst_valid", longint'(out_valid), 1);
        g0 = got_res.size();
        #1 reset_n = 1'b0;
        #1;
        chk("s6_rst_out_valid", longint'(out_valid), 0);
        chk("s6_rst_out_result", longint'(out_result), 0);
        chk("s6_rst_out_ovf", longint'(out_ovf), 0);
        #1 reset_n = 1'b1;
        exp_q.delete();
        model_acc = 0;
        @(negedge clk);
        send(1'b1, 4, 4, 0, 1'b0);
        drain();
        chk("s6_count", longint'(got_res.size() - g0), 1);
        expect_out("s6_after", g0, 16, 1'b0);

        // Random traffic with random backpressure
        for (int k = 0; k < 1500; k++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            in_mode   = $urandom_range(0, 1) == 1;
            in_clr    = ($urandom_range(0, 6) == 0);
            in_a      = ($urandom_range(0, 3) == 0) ? 8'hff : W'($urandom);
            in_b      = ($urandom_range(0, 3) == 0) ? 8'hff : W'($urandom);
            in_c      = W'($urandom);
            tick(acc, rdy);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mac_pipeline.md
Name: mac_pipeline

Overview:
Parametrised pipelined multiply-add / multiply-accumulate unit. It is the successor to the team's fixed 8-bit A*B+C register pipeline and adds the following:
- configurable operand and result widths;
- configurable output delay depth;
- a per-beat mode select (A*B+C, or accumulate A*B into a running accumulator);
- unsigned saturation with an overflow flag;
- valid/ready flow control.

It sits between a sample source and downstream filter/result logic in the arithmetic datapath.

Parameters:
WIDTH, 8, operand width of A, B, C (unsigned).
OUT_WIDTH, 16, result and accumulator width; must be >= 2*WIDTH.
PIPE_DEPTH, 3, output delay stages after the adder stage; must be >= 1. Total register stages = PIPE_DEPTH+2.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat valid
in_ready  output  1  input beat accepted when in_valid && in_ready
in_a  input  WIDTH  multiplicand
in_b  input  WIDTH  multiplier
in_c  input  WIDTH  addend (used in MADD mode only)
in_mode  input  1  0 = MADD (A*B+C), 1 = MAC (acc+A*B)
in_clr  input  1  MAC only: restart the accumulator with this beat
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
out_result  output  OUT_WIDTH  saturated result
out_ovf  output  1  this result was saturated

Behaviour:
- Reset is decided: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- While reset_n is low:
  - all stage valids, data, ovf and the accumulator are 0;
  - out_valid, out_result and out_ovf are 0;
  - in_ready is 1 after reset (pipeline empty).
- Advance enable: adv = !out_valid || out_ready.
  - All stages shift together on adv.
  - in_ready = adv (combinational).
  - When adv = 0, every stage holds, including the accumulator.
  - Bubbles (valid = 0) are carried through the stages and are not compressed.
- Stage 1 (loads on adv):
  - v1 <= in_valid && in_ready;
  - p1 <= in_a * in_b (2*WIDTH bits);
  - c1, mode1, clr1 <= inputs.
- Stage 2 (loads on adv):
  - MADD: s = p1 + zero-extended c1.
  - MAC: s = (clr1 ? 0 : acc) + p1.
  - s is computed at OUT_WIDTH+1 bits.
  - If s > 2^OUT_WIDTH-1: result = all-ones and ovf = 1. Otherwise result = s[OUT_WIDTH-1:0] and ovf = 0.
  - When adv && v1 && mode1 == MAC, acc <= result (the saturated value).
  - A MADD beat never modifies acc.
  - Bubbles do not modify acc.
- Delay stages 3..PIPE_DEPTH+2 carry {valid, result, ovf}. The last stage drives the out_* ports.
- Latency: a beat accepted at edge N appears on the outputs after edge N+PIPE_DEPTH+1 when no stall occurs. With defaults that is 5 register stages, matching the predecessor.
- Ordering is strictly preserved. No beat is dropped or duplicated under any out_ready pattern.
- Saturation is sticky in value only:
  - a saturated accumulator stays at max on further MAC beats (ovf = 1 on each);
  - it restarts only on in_clr = 1 or reset.
- in_clr = 1 with MADD mode is ignored.
- Reset mid-operation discards in-flight beats and clears acc. The first MAC beat after reset with clr = 0 yields the product alone.

Decomposition:
- Package mac_pkg holds:
  - mode typedef (enum MADD = 0, MAC = 1);
  - default-width constants;
  - a saturating-add function sat_add(a, b) that returns {ovf, result}.
- Sub-module mac_delay_line: a parametrised DEPTH x {valid, data} shift register with an enable and async active-low reset. It is used for the PIPE_DEPTH output stages.

Test Plan:
(All scenarios use default parameters.)
1. Latency check: MADD A=255, B=255, C=255, out_ready=1.
   -> out_result=65280, ovf=0; out_valid asserts after edge N+4.
2. Accumulation: MAC beats back-to-back: (10,20,clr=1), (3,4,clr=0), (1,1,clr=0).
   -> results 200, 212, 213 in order on consecutive cycles.
3. Saturation: MAC (255,255,clr=1), then (255,255), then (1,1).
   -> 65025/ovf=0, then 65535/ovf=1, then 65535/ovf=1. Then (2,2,clr=1) -> 4/ovf=0.
4. Accumulator isolation: MAC (2,3,clr=1), MADD (5,5,C=7), MAC (1,1).
   -> 6, 32, 7.
5. Backpressure: stream 8 MADD beats (A=i, B=1, C=0 for i=1..8), out_ready low for 6 cycles mid-stream.
   -> in_ready drops while stalled; outputs 1..8 exactly once, in order; acc untouched.
6. Reset mid-operation: 3 MAC beats in flight, pulse reset_n low between clock edges.
   -> out_valid/out_result/out_ovf = 0 immediately. After release, MAC (4,4,clr=0) -> 16.
